// File: rtl/regfile_byte_reader.sv
// Read-side sequencer for the 32x32 register file: fetches one register or a
// wrapping range of registers and shows each word on the LED bus byte by byte.
module regfile_byte_reader #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Scan,
    input  logic [4:0]  Start_Addr,
    input  logic [4:0]  Last_Addr,
    output logic [4:0]  Rd_Addr,
    input  logic [31:0] Rd_Data,
    output logic [7:0]  LED,
    output logic [1:0]  Byte_Idx,
    output logic        Busy,
    output logic        Done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        state_r;
    logic [4:0]        rd_addr_r;
    logic [7:0]        led_r;
    logic [1:0]        byte_idx_r;
    logic [HOLD_W-1:0] hold_r;
    logic [31:0]       word_r;
    logic [4:0]        last_addr_r;
    logic              scan_r;
    logic              busy_r;
    logic              done_r;

    function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    select_byte = w[7:0];
            2'd1:    select_byte = w[15:8];
            2'd2:    select_byte = w[23:16];
            default: select_byte = w[31:24];
        endcase
    endfunction

    // Sequencer: IDLE -> FETCH -> SHOW (4 bytes) -> FETCH next or DONE -> IDLE
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            rd_addr_r   <= 5'd0;
            led_r       <= 8'd0;
            byte_idx_r  <= 2'd0;
            hold_r      <= '0;
            word_r      <= 32'd0;
            last_addr_r <= 5'd0;
            scan_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        rd_addr_r   <= Start_Addr;
                        last_addr_r <= Last_Addr;
                        scan_r      <= Scan;
                        busy_r      <= 1'b1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Snapshot the word so later register writes cannot tear the display
                    word_r     <= Rd_Data;
                    led_r      <= Rd_Data[7:0];
                    byte_idx_r <= 2'd0;
                    hold_r     <= '0;
                    state_r    <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (hold_r == HOLD_LAST) begin
                        hold_r <= '0;
                        if (byte_idx_r != 2'd3) begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            led_r      <= select_byte(word_r, byte_idx_r + 2'd1);
                        end else if (!scan_r || (rd_addr_r == last_addr_r)) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            // 5-bit add wraps 31 -> 0 for ranges crossing the top
                            rd_addr_r <= rd_addr_r + 5'd1;
                            state_r   <= ST_FETCH;
                        end
                    end else begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Rd_Addr  = rd_addr_r;
    assign LED      = led_r;
    assign Byte_Idx = byte_idx_r;
    assign Busy     = busy_r;
    assign Done     = done_r;

endmodule

// File: tb/tb_regfile_byte_reader.sv
// Directed self-checking bench for regfile_byte_reader with a behavioural
// register file; one instance at HOLD_CYCLES=4 and one at HOLD_CYCLES=1.
module tb_regfile_byte_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        scan;
    logic [4:0]  start_addr;
    logic [4:0]  last_addr;
    logic        sel;

    logic [31:0] mem   [0:31];
    logic [31:0] exp_w [0:31];

    logic [4:0]  rd_addr4, rd_addr1;
    logic [31:0] rd_data4, rd_data1;
    logic [7:0]  led4, led1;
    logic [1:0]  byte_idx4, byte_idx1;
    logic        busy4, busy1, done4, done1;
    logic        start4, start1;

    logic [4:0]  o_rd_addr;
    logic [7:0]  o_led;
    logic [1:0]  o_byte_idx;
    logic        o_busy, o_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rd_data4 = mem[rd_addr4];
    assign rd_data1 = mem[rd_addr1];
    assign start4   = start & ~sel;
    assign start1   = start & sel;

    assign o_rd_addr  = sel ? rd_addr1  : rd_addr4;
    assign o_led      = sel ? led1      : led4;
    assign o_byte_idx = sel ? byte_idx1 : byte_idx4;
    assign o_busy     = sel ? busy1     : busy4;
    assign o_done     = sel ? done1     : done4;

    regfile_byte_reader #(.HOLD_CYCLES(4)) dut4 (
        .CLK(clk), .Reset(reset), .Start(start4), .Scan(scan),
        .Start_Addr(start_addr), .Last_Addr(last_addr),
        .Rd_Addr(rd_addr4), .Rd_Data(rd_data4), .LED(led4),
        .Byte_Idx(byte_idx4), .Busy(busy4), .Done(done4)
    );

    regfile_byte_reader #(.HOLD_CYCLES(1)) dut1 (
        .CLK(clk), .Reset(reset), .Start(start1), .Scan(scan),
        .Start_Addr(start_addr), .Last_Addr(last_addr),
        .Rd_Addr(rd_addr1), .Rd_Data(rd_data1), .LED(led1),
        .Byte_Idx(byte_idx1), .Busy(busy1), .Done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one sequence on the selected instance and checks every cycle.
    // action 1: overwrite mem[0] while [0] is on display; action 2: Start and
    // address/scan changes while busy.
    task automatic run_seq(input logic [4:0] sa, input logic [4:0] la, input logic sc,
                           input int n, input int action);
        int h;
        logic [4:0] a;
        logic [4:0] prev;
        logic [7:0] bv;
        h = sel ? 1 : 4;
        scan = sc; start_addr = sa; last_addr = la; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = sa;
        prev = sa;
        for (int r = 0; r < n; r++) begin
            check("fetch_addr", {27'd0, o_rd_addr}, {27'd0, a});
            check("fetch_busy", {31'd0, o_busy}, 32'd1);
            check("fetch_done", {31'd0, o_done}, 32'd0);
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                bv = 8'(exp_w[r] >> (8 * b));
                for (int k = 0; k < h; k++) begin
                    check("show_led", {24'd0, o_led}, {24'd0, bv});
                    check("show_idx", {30'd0, o_byte_idx}, b);
                    check("show_busy", {31'd0, o_busy}, 32'd1);
                    check("show_done", {31'd0, o_done}, 32'd0);
                    if (action == 1 && r == 0 && b == 1 && k == 0) mem[0] = 32'hFFFF_FFFF;
                    if (action == 2 && r == 0 && b == 2 && k == 1) begin
                        start = 1'b1; start_addr = 5'd9; last_addr = 5'd20; scan = ~sc;
                    end
                    if (action == 2 && r == 0 && b == 2 && k == 2) start = 1'b0;
                    @(negedge clk);
                end
            end
            prev = a;
            a = a + 5'd1;
        end
        check("done_pulse", {31'd0, o_done}, 32'd1);
        check("done_busy", {31'd0, o_busy}, 32'd1);
        check("done_addr", {27'd0, o_rd_addr}, {27'd0, prev});
        @(negedge clk);
        check("idle_done", {31'd0, o_done}, 32'd0);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_led", {24'd0, o_led}, {24'd0, exp_w[n-1][31:24]});
        check("idle_idx", {30'd0, o_byte_idx}, 32'd3);
    endtask

    initial begin
        int guard;
        logic saw_done;
        sel = 1'b0; start = 1'b0; scan = 1'b0; start_addr = 5'd0; last_addr = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_led4", {24'd0, led4}, 32'd0);
        check("rst_addr4", {27'd0, rd_addr4}, 32'd0);
        check("rst_busy4", {30'd0, busy4, done4}, 32'd0);
        check("rst_idx4", {30'd0, byte_idx4}, 32'd0);
        check("rst_led1", {24'd0, led1}, 32'd0);
        check("rst_busy1", {30'd0, busy1, done1}, 32'd0);

        // Single register
        mem[0] = 32'h0000_000F;
        exp_w[0] = 32'h0000_000F;
        run_seq(5'd0, 5'd0, 1'b0, 1, 0);

        // Range 1..3
        mem[1] = 32'h0000_0DB0; mem[2] = 32'h1234_5678; mem[3] = 32'hFFFF_FFFF;
        exp_w[0] = 32'h0000_0DB0; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'hFFFF_FFFF;
        run_seq(5'd1, 5'd3, 1'b1, 3, 0);

        // Range wrapping 31 -> 0
        mem[31] = 32'hAABB_CCDD;
        exp_w[0] = 32'hAABB_CCDD; exp_w[1] = 32'h0000_000F;
        run_seq(5'd31, 5'd0, 1'b1, 2, 0);

        // Write during display does not alter the shown word; next read sees it
        exp_w[0] = 32'h0000_000F;
        run_seq(5'd0, 5'd7, 1'b0, 1, 1);
        exp_w[0] = 32'hFFFF_FFFF;
        run_seq(5'd0, 5'd7, 1'b0, 1, 0);
        mem[0] = 32'h0000_000F;

        // Start and input changes while busy are ignored
        exp_w[0] = 32'h0000_0DB0; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'hFFFF_FFFF;
        run_seq(5'd1, 5'd3, 1'b1, 3, 2);

        // Full wrap: Start=5, Last=4 reads all 32 registers
        for (int i = 0; i < 32; i++) mem[i] = (i * 32'h0101_0101) ^ 32'h5A00_00A5;
        for (int r = 0; r < 32; r++) exp_w[r] = (((r + 5) % 32) * 32'h0101_0101) ^ 32'h5A00_00A5;
        run_seq(5'd5, 5'd4, 1'b1, 32, 0);
        mem[0] = 32'h0000_000F; mem[1] = 32'h0000_0DB0; mem[2] = 32'h1234_5678; mem[3] = 32'hFFFF_FFFF;

        // Reset during byte 2, together with a Start request
        scan = 1'b0; start_addr = 5'd2; last_addr = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (byte_idx4 != 2'd2 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("reach_byte2", {31'd0, guard < 40}, 32'd1);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("mid_rst_led", {24'd0, led4}, 32'd0);
        check("mid_rst_busy", {31'd0, busy4}, 32'd0);
        check("mid_rst_idx", {30'd0, byte_idx4}, 32'd0);
        check("mid_rst_addr", {27'd0, rd_addr4}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done4 || busy4) saw_done = 1'b1;
            @(negedge clk);
        end
        check("no_done_after_rst", {31'd0, saw_done}, 32'd0);

        // HOLD_CYCLES=1 single read of [3]
        sel = 1'b1;
        exp_w[0] = 32'hFFFF_FFFF;
        run_seq(5'd3, 5'd0, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
